// File: rtl/vregfile_stream.sv
`default_nettype none
// ============================================================================
// Module      : vregfile_stream
// Description : Scalar register file (two combinational read ports, one
//               synchronous write port, R15 = external PC) extended with a
//               sequential vector engine. The engine streams consecutive
//               registers out as operand pairs, or writes an incoming stream
//               into them, one element per valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module vregfile_stream #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 16,
  parameter int ADDR_W  = 4,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  // scalar ports
  input  logic              we3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [DATA_W-1:0] r15,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  // vector control
  input  logic              vstart,
  input  logic              vmode,
  input  logic [ADDR_W-1:0] vbase_a,
  input  logic [ADDR_W-1:0] vbase_b,
  input  logic [LEN_W-1:0]  vlen,
  output logic              vbusy,
  // vector read stream
  output logic              vout_valid,
  input  logic              vout_ready,
  output logic [DATA_W-1:0] vout_a,
  output logic [DATA_W-1:0] vout_b,
  output logic [LEN_W-1:0]  vout_idx,
  // vector write stream
  input  logic              vin_valid,
  output logic              vin_ready,
  input  logic [DATA_W-1:0] vin_data,
  output logic              vdone
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_VREAD  = 2'd1;
  localparam logic [1:0] S_VWRITE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Index of the PC slot; every index at or above it reads r15 and is not stored.
  localparam logic [ADDR_W-1:0] c_PC_IDX  = ADDR_W'(NREGS - 1);
  localparam logic [LEN_W-1:0]  c_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]  c_ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0]  c_ZERO    = '0;

  logic [DATA_W-1:0] r_regs [NREGS-1];
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base_a;
  logic [ADDR_W-1:0] r_base_b;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_vout_a;
  logic [DATA_W-1:0] r_vout_b;

  logic [LEN_W-1:0]  w_len;
  logic [LEN_W-1:0]  w_next_idx;
  logic              w_last;
  logic              w_wr_accept;
  logic [ADDR_W-1:0] w_wr_addr;

  // Architectural read: PC slot and out-of-range indices return r15.
  function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] addr);
    if (addr >= c_PC_IDX) return r15;
    return r_regs[addr];
  endfunction

  // Register index of element i with wrap-around over NREGS entries.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  i);
    logic [31:0] sum;
    sum = (32'(base) + 32'(i)) % 32'(NREGS);
    return ADDR_W'(sum);
  endfunction

  // Effective length clamp, element bookkeeping and write-stream address.
  always_comb begin
    w_len       = (vlen > c_MAX_LEN) ? c_MAX_LEN : vlen;
    w_next_idx  = r_idx + c_ONE;
    w_last      = (w_next_idx == r_len);
    w_wr_accept = (r_state == S_VWRITE) && vin_valid;
    w_wr_addr   = elem_addr(r_base_a, r_idx);
  end

  // Combinational scalar reads, no write bypass.
  always_comb begin
    rd1 = read_reg(ra1);
    rd2 = read_reg(ra2);
  end

  // Storage: scalar write first, vector write second so it wins a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREGS - 1; k++) r_regs[k] <= '0;
    end else begin
      if (we3 && (wa3 < c_PC_IDX)) r_regs[wa3] <= wd3;
      if (w_wr_accept && (w_wr_addr < c_PC_IDX)) r_regs[w_wr_addr] <= vin_data;
    end
  end

  // Vector engine FSM with registered element pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_base_a <= '0;
      r_base_b <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_vout_a <= '0;
      r_vout_b <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (vstart) begin
            r_base_a <= vbase_a;
            r_base_b <= vbase_b;
            r_len    <= w_len;
            r_idx    <= '0;
            if (w_len == c_ZERO) begin
              r_state <= S_DONE;
            end else if (!vmode) begin
              r_state  <= S_VREAD;
              r_vout_a <= read_reg(elem_addr(vbase_a, c_ZERO));
              r_vout_b <= read_reg(elem_addr(vbase_b, c_ZERO));
            end else begin
              r_state <= S_VWRITE;
            end
          end
        end
        S_VREAD: begin
          if (vout_ready) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx    <= w_next_idx;
              r_vout_a <= read_reg(elem_addr(r_base_a, w_next_idx));
              r_vout_b <= read_reg(elem_addr(r_base_b, w_next_idx));
            end
          end
        end
        S_VWRITE: begin
          if (vin_valid) begin
            if (w_last) r_state <= S_DONE;
            else        r_idx   <= w_next_idx;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Status and stream outputs decoded from state and held registers.
  always_comb begin
    vbusy      = (r_state != S_IDLE);
    vout_valid = (r_state == S_VREAD);
    vin_ready  = (r_state == S_VWRITE);
    vdone      = (r_state == S_DONE);
    vout_a     = r_vout_a;
    vout_b     = r_vout_b;
    vout_idx   = r_idx;
  end

endmodule
`default_nettype wire

// File: tb/tb_vregfile_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_vregfile_stream
// Description : Self-checking bench for vregfile_stream. Scalar table vectors,
//               directed multi-cycle stream sequences and randomized stream
//               operations checked against an array model of the registers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vregfile_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        we3;
  logic [3:0]  ra1, ra2, wa3;
  logic [31:0] wd3, r15, rd1, rd2;
  logic        vstart, vmode;
  logic [3:0]  vbase_a, vbase_b, vlen;
  logic        vbusy, vout_valid, vout_ready;
  logic [31:0] vout_a, vout_b;
  logic [3:0]  vout_idx;
  logic        vin_valid, vin_ready;
  logic [31:0] vin_data;
  logic        vdone;

  always #5 clk = ~clk;

  vregfile_stream dut (
    .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2), .wa3(wa3),
    .wd3(wd3), .r15(r15), .rd1(rd1), .rd2(rd2), .vstart(vstart), .vmode(vmode),
    .vbase_a(vbase_a), .vbase_b(vbase_b), .vlen(vlen), .vbusy(vbusy),
    .vout_valid(vout_valid), .vout_ready(vout_ready), .vout_a(vout_a),
    .vout_b(vout_b), .vout_idx(vout_idx), .vin_valid(vin_valid),
    .vin_ready(vin_ready), .vin_data(vin_data), .vdone(vdone)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the 15 stored registers; index 15 reads r15.
  logic [31:0] m_regs [0:14];

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [31:0] pc;
    logic [31:0] pre1;
    logic [31:0] post1;
    logic [31:0] post2;
  } svec_t;

  svec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rd(input int a);
    if (a >= 15) return r15;
    return m_regs[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 15; k++) m_regs[k] = '0;
  endtask

  task automatic scalar_write(input int a, input logic [31:0] d);
    we3 = 1'b1; wa3 = 4'(a); wd3 = d;
    tick();
    we3 = 1'b0;
    if (a < 15) m_regs[a] = d;
  endtask

  task automatic check_all(input string name);
    for (int a = 0; a < 16; a++) begin
      ra1 = 4'(a); ra2 = 4'(15 - a);
      #1;
      chk(name, rd1, m_rd(a));
      chk(name, rd2, m_rd(15 - a));
    end
    tick();
  endtask

  // Completion: vdone high for exactly one cycle, then back to idle.
  task automatic finish_op(input string name);
    #1;
    chk({name, "_vdone"}, 32'(vdone), 32'd1);
    chk({name, "_done_valid"}, 32'(vout_valid | vin_ready), 32'd0);
    tick();
    chk({name, "_vdone_once"}, 32'(vdone), 32'd0);
    chk({name, "_idle"}, 32'(vbusy), 32'd0);
  endtask

  task automatic vread(input int ba, input int bb, input int len,
                       input int stall_idx, input int stall_n, input int rand_pct,
                       input bit poke, input bit do_wr, input int wr_a,
                       input logic [31:0] wr_d);
    int L, k, stalls, cyc;
    bit rdy, poked, wrote;
    logic [31:0] ea [$];
    logic [31:0] eb [$];
    L = (len > 8) ? 8 : len;
    for (int j = 0; j < L; j++) begin
      ea.push_back(m_rd((ba + j) % 16));
      eb.push_back(m_rd((bb + j) % 16));
    end
    vstart = 1'b1; vmode = 1'b0; vbase_a = 4'(ba); vbase_b = 4'(bb); vlen = 4'(len);
    tick();
    vstart = 1'b0;
    k = 0; stalls = 0; cyc = 0; poked = 0; wrote = 0;
    while (k < L && cyc < 200) begin
      rdy = 1'b1;
      if (k == stall_idx && stalls < stall_n) begin
        rdy = 1'b0; stalls++;
      end else if (cyc < 150 && $urandom_range(99) < rand_pct) begin
        rdy = 1'b0;
      end
      vout_ready = rdy;
      if (poke && k == 1 && !poked) begin
        vstart = 1'b1; vmode = 1'b1; vbase_a = 4'(ba + 3); vlen = 4'd2; poked = 1;
      end
      if (do_wr && !rdy && k == stall_idx && !wrote) begin
        we3 = 1'b1; wa3 = 4'(wr_a); wd3 = wr_d; wrote = 1;
      end
      #1;
      chk("vrd_valid", 32'(vout_valid), 32'd1);
      chk("vrd_a", vout_a, ea[k]);
      chk("vrd_b", vout_b, eb[k]);
      chk("vrd_idx", 32'(vout_idx), 32'(k));
      tick();
      vstart = 1'b0;
      if (we3) begin
        if (wa3 != 4'd15) m_regs[wa3] = wd3;
        we3 = 1'b0;
      end
      if (rdy) k++;
      cyc++;
    end
    vout_ready = 1'b0;
    finish_op("vrd");
  endtask

  task automatic vwrite(input int ba, input int len, input int gap_pct,
                        input bit coll, input int coll_a, input bit rnd_sc,
                        input logic [31:0] dbase);
    int L, k, cyc, a;
    bit vld;
    logic [31:0] dat [$];
    L = (len > 8) ? 8 : len;
    for (int j = 0; j < L; j++) dat.push_back((dbase != 0) ? dbase + 32'(j) : $urandom);
    vstart = 1'b1; vmode = 1'b1; vbase_a = 4'(ba); vbase_b = 4'($urandom); vlen = 4'(len);
    tick();
    vstart = 1'b0;
    k = 0; cyc = 0;
    while (k < L && cyc < 200) begin
      vld = (cyc > 50) || ($urandom_range(99) >= gap_pct);
      vin_valid = vld;
      vin_data = vld ? dat[k] : $urandom;
      if (coll && vld && k == 1) begin
        we3 = 1'b1; wa3 = 4'(coll_a); wd3 = 32'h55;
      end else if (rnd_sc && $urandom_range(1) == 1) begin
        we3 = 1'b1; wa3 = 4'($urandom); wd3 = $urandom;
      end
      #1;
      chk("vwr_ready", 32'(vin_ready), 32'd1);
      chk("vwr_busy", 32'(vbusy), 32'd1);
      tick();
      if (we3 && wa3 != 4'd15) m_regs[wa3] = wd3;
      if (vld) begin
        a = (ba + k) % 16;
        if (a < 15) m_regs[a] = dat[k];
        k++;
      end
      we3 = 1'b0; vin_valid = 1'b0;
      cyc++;
    end
    finish_op("vwr");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; we3 = 0; ra1 = 0; ra2 = 0; wa3 = 0; wd3 = 0; r15 = 32'h100;
    vstart = 0; vmode = 0; vbase_a = 0; vbase_b = 0; vlen = 0;
    vout_ready = 0; vin_valid = 0; vin_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vbusy", 32'(vbusy), 32'd0);
    chk("rst_vout_valid", 32'(vout_valid), 32'd0);
    chk("rst_vin_ready", 32'(vin_ready), 32'd0);
    chk("rst_vdone", 32'(vdone), 32'd0);
    chk("rst_vout_a", vout_a, 32'd0);
    chk("rst_vout_b", vout_b, 32'd0);
    chk("rst_vout_idx", 32'(vout_idx), 32'd0);
    reset = 1'b0;
    model_clear();
    tick();

    // Fill registers, start a stream and abort it with reset.
    for (int k = 0; k < 15; k++) scalar_write(k, $urandom | 32'h1);
    vstart = 1'b1; vmode = 1'b0; vbase_a = 4'd0; vbase_b = 4'd4; vlen = 4'd6; vout_ready = 1'b1;
    tick();
    vstart = 1'b0;
    tick();
    chk("mid_busy", 32'(vbusy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_vbusy", 32'(vbusy), 32'd0);
    chk("abort_valid", 32'(vout_valid), 32'd0);
    chk("abort_idx", 32'(vout_idx), 32'd0);
    chk("abort_vout_a", vout_a, 32'd0);
    tick();
    reset = 1'b0;
    vout_ready = 1'b0;
    model_clear();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("abort_no_vdone", 32'(vdone), 32'd0);
      tick();
    end
    check_all("rst_regs_zero");

    // Scalar table: expected rd1 before the edge, rd1/rd2 after it.
    tbl[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 4'd3,  4'd15, 32'h100, 32'h0,        32'hDEADBEEF, 32'h100};
    tbl[1] = '{1'b1, 4'd15, 32'h12345678, 4'd15, 4'd3,  32'h200, 32'h200,      32'h200,      32'hDEADBEEF};
    tbl[2] = '{1'b0, 4'd3,  32'h0,        4'd3,  4'd0,  32'h0,   32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    tbl[3] = '{1'b1, 4'd0,  32'hA5A5A5A5, 4'd0,  4'd14, 32'h0,   32'h0,        32'hA5A5A5A5, 32'h0};
    tbl[4] = '{1'b1, 4'd14, 32'hCAFEF00D, 4'd14, 4'd0,  32'h7,   32'h0,        32'hCAFEF00D, 32'hA5A5A5A5};
    for (int i = 0; i < 5; i++) begin
      we3 = tbl[i].we; wa3 = tbl[i].wa; wd3 = tbl[i].wd;
      ra1 = tbl[i].a1; ra2 = tbl[i].a2; r15 = tbl[i].pc;
      #1;
      chk("tbl_pre_rd1", rd1, tbl[i].pre1);
      tick();
      we3 = 1'b0;
      #1;
      chk("tbl_post_rd1", rd1, tbl[i].post1);
      chk("tbl_post_rd2", rd2, tbl[i].post2);
      if (tbl[i].we && tbl[i].wa != 4'd15) m_regs[tbl[i].wa] = tbl[i].wd;
    end
    tick();

    // Plain vector read: pairs (10,1),(20,2),(30,3),(40,4).
    for (int k = 0; k < 4; k++) begin
      scalar_write(1 + k, 32'(10 * (k + 1)));
      scalar_write(5 + k, 32'(k + 1));
    end
    vread(1, 5, 4, -1, 0, 0, 1'b0, 1'b0, 0, 32'h0);

    // Backpressure at idx 1 for three cycles with a write to R2 meanwhile.
    vread(1, 5, 4, 1, 3, 0, 1'b0, 1'b1, 2, 32'h99);
    ra1 = 4'd2;
    #1;
    chk("bp_r2_after", rd1, 32'h99);
    tick();

    // Wrap-around through the PC slot.
    r15 = 32'h1234_5678;
    scalar_write(13, 32'h1313);
    scalar_write(14, 32'h1414);
    vread(13, 3, 4, -1, 0, 0, 1'b0, 1'b0, 0, 32'h0);

    // Vector write with gaps and a colliding scalar write on element 1.
    vwrite(6, 3, 40, 1'b1, 7, 1'b0, 32'd7);
    ra1 = 4'd6; ra2 = 4'd7;
    #1;
    chk("vwr_r6", rd1, 32'd7);
    chk("vwr_r7_collision", rd2, 32'd8);
    ra1 = 4'd8;
    #1;
    chk("vwr_r8", rd1, 32'd9);
    tick();

    // Edge lengths and ignored vstart while busy.
    vread(3, 4, 0, -1, 0, 0, 1'b0, 1'b0, 0, 32'h0);
    vwrite(3, 0, 0, 1'b0, 0, 1'b0, 32'h0);
    vread(2, 9, 12, -1, 0, 20, 1'b0, 1'b0, 0, 32'h0);
    vwrite(10, 12, 20, 1'b0, 0, 1'b0, 32'h0);
    check_all("len12_regs");
    vread(0, 8, 6, -1, 0, 0, 1'b1, 1'b0, 0, 32'h0);
    check_all("poke_regs");

    // Randomized operations against the model.
    for (int it = 0; it < 24; it++) begin
      r15 = $urandom;
      if ($urandom_range(1) == 0)
        vread($urandom_range(15), $urandom_range(15), $urandom_range(15), -1, 0, 30,
              1'b0, 1'b0, 0, 32'h0);
      else
        vwrite($urandom_range(15), $urandom_range(15), 30, 1'b0, 0, 1'b1, 32'h0);
    end
    check_all("rand_regs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
